instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch front-end that sits directly upstream of the 3-cycle-latency instruction ROM. It walks a program counter over a requested address range, issues one ROM read per cycle under credit control, and captures the returned words into a small in-order queue. The queue feeds the decoder over a valid/ready handshake. A halt request flushes everything in flight.

## Interface
- `ADDR_W`, 13: ROM word-address width; matches `IMSZLOG2`.
- `INSTR_W`, 32: instruction width; matches `INSTRW`.
- `LAT`, 3: ROM read latency in cycles, from `ren` high to `ins_valid` high.
- `DEPTH`, 8: output queue entries; power of two, ≥ 2. Full throughput requires `DEPTH` ≥ `LAT`+2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; one clock, asynchronous, active-low.
- `start_i`, in, 1: start pulse; accepted only in IDLE.
- `start_addr_i`, in, `ADDR_W`: first word address.
- `len_i`, in, `ADDR_W`+1: number of words to fetch.
- `halt_i`, in, 1: abort request; level-sampled each cycle.
- `mem_addr_o`, out, `ADDR_W`: ROM address; 0 whenever `mem_ren_o`=0.
- `mem_ren_o`, out, 1: ROM read enable; registered.
- `mem_halt_o`, out, 1: ROM halt; registered copy of `halt_i`.
- `mem_data_i`, in, `INSTR_W`: ROM data (`im_o`).
- `mem_valid_i`, in, 1: ROM data valid (`ins_valid`).
- `out_valid_o`, out, 1: queue head valid.
- `out_ready_i`, in, 1: consumer ready.
- `out_instr_o`, out, `INSTR_W`: queue head instruction.
- `out_pc_o`, out, `ADDR_W`: address of the queue head.
- `busy_o`, out, 1: state ≠ IDLE.
- `done_o`, out, 1: one-cycle pulse when a run completes normally.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE**
  - On `start_i`, load `pc`←`start_addr_i`, `head_pc`←`start_addr_i`, `remaining`←`len_i`.
  - Enter FETCH, or DRAIN if `len_i`=0.
- **FETCH**
  - Issue when `remaining`>0 and `count`+`inflight` < `DEPTH`. Issue means: next cycle `mem_ren_o`=1 and `mem_addr_o`=`pc`; then `pc`←`pc`+1 mod 2^`ADDR_W` and `remaining`−1.
  - Enter DRAIN the cycle `remaining` reaches 0.
- **DRAIN**
  - When `inflight`=0 and `count`=0, return to IDLE and pulse `done_o`.
- **In-flight tracking**
  - `inflight` counts issues not yet returned. It increments on issue and decrements on `mem_valid_i`; both in the same cycle leaves it unchanged.
  - Ceiling is `LAT`+1, so the counter is width clog2(`LAT`+2).
- **Queue**
  - Push `mem_data_i` when `mem_valid_i`=1. Pop when `out_valid_o` & `out_ready_i`; `head_pc` increments mod 2^`ADDR_W` on each pop.
  - Simultaneous push and pop are allowed when full or empty. The credit rule guarantees no overflow.
  - Pointers wrap mod `DEPTH`.
- `mem_valid_i` arriving in IDLE, or with `inflight`=0, is a protocol error. Drop it; it is assertion-flagged in simulation.
- **Halt** (any state, `halt_i`=1)
  - Next cycle: FSM to IDLE, queue emptied, `inflight`←0, `remaining`←0, `mem_ren_o`=0.
  - `mem_valid_i` is ignored for the following `LAT` cycles.
  - No `done_o` pulse.
  - `start_i` in the same cycle as `halt_i` is ignored.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - `pc`, `head_pc`, `remaining`, `inflight`, `count`, and pointers all 0.
  - FSM in IDLE.
- Start latency: `start_i` at cycle T gives first `mem_ren_o` at T+1.
- Data latency:
  - ROM data returns at T+1+`LAT`.
  - `out_valid_o` rises at T+2+`LAT`, so 5 cycles after start with defaults.
- Steady state: one issue and one instruction delivered per cycle while `out_ready_i`=1.
- `done_o` fires the cycle after the last pop.
- Reset asserted mid-run returns everything to reset values immediately, without waiting for a clock edge.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds outputs `perf_stall_o` (32-bit) and `perf_fetch_o` (32-bit).
  - `perf_stall_o` counts FETCH cycles with `remaining`>0 and no issue.
  - `perf_fetch_o` counts issues.
  - Both clear on `start_i` accepted and on reset, and saturate at all-ones.
- `IFETCH_PERF_EN` undefined: no counters and no ports.

## Test plan
- `start_addr`=0x010, `len`=5, ready=1:
  - `mem_ren_o` high for 5 consecutive cycles, addresses 0x010–0x014.
  - Outputs come in order with `out_pc` 0x010–0x014.
  - One `done_o` pulse.
- Backpressure, `len`=20, ready=0:
  - Exactly 8 issues, then `mem_ren_o` stays 0 while `out_valid_o`=1.
  - Raise ready: all 20 words delivered in order, no loss or duplication.
- Halt two cycles after the third issue:
  - `mem_halt_o` pulses; `out_valid_o`=0 and `busy_o`=0 next cycle.
  - No `done_o`.
  - Injected stray `mem_valid_i` in the `LAT`-cycle window is not queued.
- Wrap, `start_addr`=0x1FFE, `len`=4: addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001, with matching `out_pc`.
- `len`=0: `done_o` two cycles after start, no `mem_ren_o`.
- With `IFETCH_PERF_EN`: rerun the backpressure case with ready=0 for 10 cycles and check `perf_fetch_o`=20 and `perf_stall_o`≥10 at `done_o`.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: ROM request/response plus the decoder-facing valid/ready queue head.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned INSTR_W = 32
) ();
  logic [ADDR_W-1:0]  mem_addr_o;
  logic               mem_ren_o;
  logic               mem_halt_o;
  logic [INSTR_W-1:0] mem_data_i;
  logic               mem_valid_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [INSTR_W-1:0] out_instr_o;
  logic [ADDR_W-1:0]  out_pc_o;

  modport master (
    output mem_addr_o, mem_ren_o, mem_halt_o, out_valid_o, out_instr_o, out_pc_o,
    input  mem_data_i, mem_valid_i, out_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_ren_o, mem_halt_o, out_valid_o, out_instr_o, out_pc_o,
    output mem_data_i, mem_valid_i, out_ready_i
  );
endinterface

// File: rtl/instr_fetch.sv
// Credit-controlled instruction fetch front-end feeding an in-order queue from a fixed-latency ROM.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned LAT     = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              halt_i,
  instr_fetch_if.master     bus,
  output logic              busy_o,
  output logic              done_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_fetch_o
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(LAT + 2);
  localparam int unsigned GW = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [GW-1:0] LAT_C   = GW'(LAT);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  head_pc;
  logic [ADDR_W:0]    remaining;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [GW-1:0]      ign_cnt;
  logic               mem_ren_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_halt_q;
  logic               done_q;
  logic [INSTR_W-1:0] fifo [DEPTH];

  logic              start_ok;
  logic              issue_start;
  logic              issue_fetch;
  logic              issue;
  logic              accept;
  logic              pop;
  logic              drain_done;
  logic [ADDR_W-1:0] issue_addr;
  logic [CW:0]       occupancy;

  // The first read is issued in the same cycle the start is accepted, so
  // mem_ren_o rises one cycle after start_i.
  always_comb begin
    start_ok    = (state == IDLE) && start_i && !halt_i;
    issue_start = start_ok && (len_i != '0);
    occupancy   = (CW+1)'(count) + (CW+1)'(inflight);
    issue_fetch = (state == FETCH) && !halt_i && (remaining != '0) && (occupancy < DEPTH_C);
    issue       = issue_start || issue_fetch;
    issue_addr  = issue_start ? start_addr_i : pc;
    accept      = bus.mem_valid_i && (ign_cnt == '0) && (state != IDLE) && (inflight != '0);
    pop         = (count != '0) && bus.out_ready_i;
    // Looking through the final pop lets done_o land the cycle after it.
    drain_done  = (inflight == '0) && ((count == '0) || ((count == CW'(1)) && pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      head_pc    <= '0;
      remaining  <= '0;
      inflight   <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ign_cnt    <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_halt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_halt_q <= halt_i;
      if (halt_i) begin
        // Reads already issued still return; the window masks them.
        state      <= IDLE;
        remaining  <= '0;
        inflight   <= '0;
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        ign_cnt    <= LAT_C;
        mem_ren_q  <= 1'b0;
        mem_addr_q <= '0;
        done_q     <= 1'b0;
      end else begin
        mem_ren_q  <= issue;
        mem_addr_q <= issue ? issue_addr : '0;
        done_q     <= 1'b0;
        if (ign_cnt != '0) ign_cnt <= ign_cnt - GW'(1);
        if (issue) pc <= issue_addr + ADDR_W'(1);

        case (state)
          IDLE: begin
            if (start_ok) begin
              head_pc   <= start_addr_i;
              remaining <= issue_start ? (len_i - (ADDR_W+1)'(1)) : '0;
              if (!issue_start) pc <= start_addr_i;
              state     <= (len_i > (ADDR_W+1)'(1)) ? FETCH : DRAIN;
            end
          end
          FETCH: begin
            if (issue_fetch) begin
              remaining <= remaining - (ADDR_W+1)'(1);
              if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (drain_done) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        case ({issue, accept})
          2'b10:   inflight <= inflight + IW'(1);
          2'b01:   inflight <= inflight - IW'(1);
          default: ;
        endcase

        if (accept) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          head_pc <= head_pc + ADDR_W'(1);
        end

        case ({accept, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= bus.mem_data_i;
  end

  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_ren_o   = mem_ren_q;
  assign bus.mem_halt_o  = mem_halt_q;
  assign bus.out_valid_o = (count != '0);
  assign bus.out_instr_o = (count != '0) ? fifo[rd_ptr] : '0;
  assign bus.out_pc_o    = head_pc;
  assign busy_o          = (state != IDLE);
  assign done_o          = done_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] fetch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      fetch_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
      fetch_q <= issue_start ? 32'd1 : 32'd0;
    end else begin
      if (issue && (fetch_q != '1)) fetch_q <= fetch_q + 32'd1;
      if ((state == FETCH) && (remaining != '0) && !issue && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_fetch_o = fetch_q;
`endif

`ifndef SYNTHESIS
  // Returned data with nothing outstanding (outside the post-halt window) is a ROM protocol error.
  always_ff @(posedge clk) begin
    if (rst_n && bus.mem_valid_i && (ign_cnt == '0) && !halt_i)
      assert ((state != IDLE) && (inflight != '0))
        else $error("instr_fetch: mem_valid_i with no read outstanding");
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 3-cycle ROM model and a recording monitor.
module tb_instr_fetch;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned LAT     = 3;
  localparam int unsigned DEPTH   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] start_addr_i = '0;
  logic [ADDR_W:0]   len_i = '0;
  logic              halt_i = 1'b0;
  logic              ready = 1'b0;
  logic              stray = 1'b0;
  logic              busy_o;
  logic              done_o;
`ifdef IFETCH_PERF_EN
  logic [31:0]       perf_stall;
  logic [31:0]       perf_fetch;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc;
  logic [ADDR_W-1:0]  iss_q [$];
  logic [ADDR_W-1:0]  pc_q  [$];
  logic [INSTR_W-1:0] ins_q [$];
  logic [ADDR_W-1:0]  wrap_exp [4];

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .len_i        (len_i),
    .halt_i       (halt_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_o (perf_stall),
    .perf_fetch_o (perf_fetch)
`endif
  );

  // ROM: data for address a is 0x5A000000 | a, valid LAT cycles after ren.
  logic [LAT-1:0]    vpipe;
  logic [ADDR_W-1:0] apipe [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe <= '0;
    else        vpipe <= {vpipe[LAT-2:0], bus.mem_ren_o};
  end

  always @(posedge clk) begin
    apipe[0] <= bus.mem_addr_o;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end

  assign bus.mem_valid_i = vpipe[LAT-1] | stray;
  assign bus.mem_data_i  = 32'h5A00_0000 | 32'(apipe[LAT-1]);
  assign bus.out_ready_i = ready;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.mem_ren_o) iss_q.push_back(bus.mem_addr_o);
      if (bus.out_valid_o && bus.out_ready_i) begin
        pc_q.push_back(bus.out_pc_o);
        ins_q.push_back(bus.out_instr_o);
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    iss_q.delete();
    pc_q.delete();
    ins_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    wrap_exp[0] = 13'h1FFE;
    wrap_exp[1] = 13'h1FFF;
    wrap_exp[2] = 13'h0000;
    wrap_exp[3] = 13'h0001;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ren",   32'(bus.mem_ren_o),   0);
    chk("rst_addr",  32'(bus.mem_addr_o),  0);
    chk("rst_halt",  32'(bus.mem_halt_o),  0);
    chk("rst_valid", 32'(bus.out_valid_o), 0);
    chk("rst_instr", bus.out_instr_o,      0);
    chk("rst_pc",    32'(bus.out_pc_o),    0);
    chk("rst_busy",  32'(busy_o),          0);
    chk("rst_done",  32'(done_o),          0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run 0x010, len 5; a second start mid-run must be ignored
    clear_rec();
    ready = 1'b1;
    start_i = 1'b1; start_addr_i = 13'h010; len_i = 14'd5;
    @(negedge clk);
    start_i = 1'b0;
    chk("t1_busy",       32'(busy_o),         1);
    chk("t1_ren_first",  32'(bus.mem_ren_o),  1);
    chk("t1_addr_first", 32'(bus.mem_addr_o), 32'h010);
    @(negedge clk);
    start_i = 1'b1; start_addr_i = 13'h777; len_i = 14'd3;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("t1_valid_early", 32'(bus.out_valid_o), 0);
    @(negedge clk);
    chk("t1_valid_lat", 32'(bus.out_valid_o), 1);
    chk("t1_head_pc",   32'(bus.out_pc_o),    32'h010);
    chk("t1_head_ins",  bus.out_instr_o,      32'h5A00_0010);
    wait_done(20, cyc);
    chk("t1_done_lat", 32'(cyc), 5);
    chk("t1_done_idle", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
    chk("t1_issue_n", 32'(iss_q.size()), 5);
    for (int i = 0; i < 5 && i < iss_q.size(); i++)
      chk("t1_issue_addr", 32'(iss_q[i]), 32'h010 + 32'(i));
    chk("t1_out_n", 32'(pc_q.size()), 5);
    for (int i = 0; i < 5 && i < pc_q.size(); i++) begin
      chk("t1_out_pc",  32'(pc_q[i]), 32'h010 + 32'(i));
      chk("t1_out_ins", ins_q[i],     32'h5A00_0010 + 32'(i));
    end
    chk("t1_done_cnt", 32'(done_cnt), 1);

    // Backpressure: len 20 with ready low for 20 cycles
    clear_rec();
    ready = 1'b0;
    start_i = 1'b1; start_addr_i = 13'h100; len_i = 14'd20;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    chk("t2_issue_cap", 32'(iss_q.size()),     8);
    chk("t2_ren_stall", 32'(bus.mem_ren_o),    0);
    chk("t2_valid_hold", 32'(bus.out_valid_o), 1);
    chk("t2_head_pc",   32'(bus.out_pc_o),     32'h100);
    ready = 1'b1;
    wait_done(100, cyc);
    chk("t2_done_seen", 32'(done_o), 1);
`ifdef IFETCH_PERF_EN
    chk("t2_perf_fetch", perf_fetch, 20);
    chk("t2_perf_stall_ge10", 32'(perf_stall >= 32'd10), 1);
`endif
    repeat (2) @(negedge clk);
    chk("t2_out_n", 32'(pc_q.size()), 20);
    for (int i = 0; i < 20 && i < pc_q.size(); i++) begin
      chk("t2_out_pc",  32'(pc_q[i]), 32'h100 + 32'(i));
      chk("t2_out_ins", ins_q[i],     32'h5A00_0100 + 32'(i));
    end
    chk("t2_done_cnt", 32'(done_cnt), 1);

    // Halt two cycles after the third issue, stray valids in the masked window
    clear_rec();
    ready = 1'b1;
    start_i = 1'b1; start_addr_i = 13'h200; len_i = 14'd10;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_third_addr", 32'(bus.mem_addr_o), 32'h202);
    @(negedge clk);
    @(negedge clk);
    halt_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0;
    stray = 1'b1;
    chk("t3_mem_halt", 32'(bus.mem_halt_o),  1);
    chk("t3_valid",    32'(bus.out_valid_o), 0);
    chk("t3_busy",     32'(busy_o),          0);
    chk("t3_ren",      32'(bus.mem_ren_o),   0);
    @(negedge clk);
    chk("t3_halt_pulse", 32'(bus.mem_halt_o), 0);
    @(negedge clk);
    @(negedge clk);
    stray = 1'b0;
    chk("t3_no_stray", 32'(bus.out_valid_o), 0);
    repeat (3) @(negedge clk);
    chk("t3_valid_after", 32'(bus.out_valid_o), 0);
    chk("t3_busy_after",  32'(busy_o),          0);
    chk("t3_no_done",     32'(done_cnt),        0);

    // Address wrap at the top of the ROM
    clear_rec();
    start_i = 1'b1; start_addr_i = 13'h1FFE; len_i = 14'd4;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(30, cyc);
    chk("t4_done_seen", 32'(done_o), 1);
    repeat (2) @(negedge clk);
    chk("t4_issue_n", 32'(iss_q.size()), 4);
    chk("t4_out_n",   32'(pc_q.size()),  4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      chk("t4_issue_addr", 32'(iss_q[i]), 32'(wrap_exp[i]));
    for (int i = 0; i < 4 && i < pc_q.size(); i++) begin
      chk("t4_out_pc",  32'(pc_q[i]), 32'(wrap_exp[i]));
      chk("t4_out_ins", ins_q[i],     32'h5A00_0000 | 32'(wrap_exp[i]));
    end

    // Asynchronous reset mid-run
    clear_rec();
    start_i = 1'b1; start_addr_i = 13'h300; len_i = 14'd10;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_ren_running", 32'(bus.mem_ren_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy",  32'(busy_o),         0);
    chk("t5_ren",   32'(bus.mem_ren_o),  0);
    chk("t5_addr",  32'(bus.mem_addr_o), 0);
    chk("t5_pc",    32'(bus.out_pc_o),   0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length run
    clear_rec();
    start_i = 1'b1; start_addr_i = 13'h050; len_i = 14'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("t6_busy",     32'(busy_o),        1);
    chk("t6_ren",      32'(bus.mem_ren_o), 0);
    chk("t6_done_t1",  32'(done_o),        0);
    @(negedge clk);
    chk("t6_done_t2",  32'(done_o),        1);
    chk("t6_idle",     32'(busy_o),        0);
    @(negedge clk);
    chk("t6_done_once", 32'(done_o),       0);
    chk("t6_no_issue", 32'(iss_q.size()),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
